// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared constants and FSM state type for the CPU boot controller.
// Instruction-memory depth is tied to the word-address width.
package cpu_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Image-load handshake and instruction-memory write port of the boot controller.
// The master side is the loader plus the memory; the slave side is the controller.
interface cpu_boot_ctrl_if #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);
  import cpu_pkg::*;

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/cpu_boot_ctrl.sv
// Boot controller: streams an instruction image into memory, then runs,
// halts and single-steps the core through its reset and clock enable.
module cpu_boot_ctrl #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DEPTH  = cpu_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  cpu_boot_ctrl_if.slave    bus,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   word_cnt,
  output logic              ovf_err
);
  import cpu_pkg::*;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ovf_q, ovf_d;
  logic                we_q, we_d;
  logic                rdy_q, rdy_d;
  logic                crst_q, crst_d;
  logic                cen_q, cen_d;
  logic                hs;
  logic                step;

  // Next state, load datapath and registered core controls
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    step    = 1'b0;
    hs      = rdy_q && bus.ld_valid;

    case (state_q)
      ST_IDLE: begin
        if (load_req)     state_d = ST_LOAD;
        else if (run_req) state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (hs && (bus.ld_last || cnt_q == LAST_ADDR)) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (load_req)      state_d = ST_LOAD;
        else if (halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (load_req)     state_d = ST_LOAD;
        else if (run_req) state_d = ST_RUN;
        else              step    = step_req;
      end
      default: state_d = ST_IDLE;
    endcase

    if (hs) begin
      we_d    = 1'b1;
      addr_d  = cnt_q[ADDR_W-1:0];
      wdata_d = bus.ld_data;
      cnt_d   = cnt_q + (ADDR_W+1)'(1);
      if (!bus.ld_last && cnt_q == LAST_ADDR) ovf_d = 1'b1;
    end

    // A fresh load restarts the counter and clears the sticky overflow
    if (state_d == ST_LOAD && state_q != ST_LOAD) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    rdy_d  = (state_d == ST_LOAD);
    crst_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    cen_d  = (state_d == ST_RUN) || step;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      crst_q  <= 1'b1;
      cen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      crst_q  <= crst_d;
      cen_q   <= cen_d;
    end
  end

  assign state_o        = state_q;
  assign word_cnt       = cnt_q;
  assign ovf_err        = ovf_q;
  assign cpu_rst        = crst_q;
  assign cpu_en         = cen_q;
  assign bus.ld_ready   = rdy_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Bench for cpu_boot_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_cpu_boot_ctrl;
  localparam int unsigned AW = 12;
  localparam int unsigned DP = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_req = 1'b0, run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
  logic cpu_rst, cpu_en, ovf_err;
  logic [1:0]  state_o;
  logic [AW:0] word_cnt;

  cpu_boot_ctrl_if #(.ADDR_W(AW)) bus ();

  cpu_boot_ctrl #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .load_req(load_req), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .bus(bus),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .state_o(state_o),
    .word_cnt(word_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 loading, 2 running, 3 halted
  int          m_mode = 0;
  int          m_cnt = 0;
  bit          m_ovf = 0, m_we = 0, m_in_rst = 0, m_step = 0, started = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          m_next;
  bit          m_take;

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_ovf = 0; m_we = 0; m_step = 0;
      m_addr = '0; m_wdata = '0; m_in_rst = 1; started = 1;
    end else if (started) begin
      m_in_rst = 0;
      m_take   = (m_mode == 1) && (bus.ld_valid === 1'b1);
      m_we     = m_take;
      m_step   = 0;
      m_next   = m_mode;
      if (m_take) begin
        m_addr  = AW'(m_cnt);
        m_wdata = bus.ld_data;
        m_cnt   = m_cnt + 1;
        if (bus.ld_last) m_next = 0;
        else if (m_cnt == DP) begin m_next = 0; m_ovf = 1; end
      end
      if (m_mode == 0) begin
        if (load_req) m_next = 1; else if (run_req) m_next = 2;
      end else if (m_mode == 2) begin
        if (load_req) m_next = 1; else if (halt_req) m_next = 3;
      end else if (m_mode == 3) begin
        if (load_req) m_next = 1; else if (run_req) m_next = 2; else if (step_req) m_step = 1;
      end
      if (m_next == 1 && m_mode != 1) begin m_cnt = 0; m_ovf = 0; end
      m_mode = m_next;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (started) begin
      chk("state_o", 64'(state_o), 64'(m_mode));
      chk("ld_ready", 64'(bus.ld_ready), 64'(m_mode == 1));
      chk("imem_we", 64'(bus.imem_we), 64'(m_we));
      if (m_we || m_in_rst) begin
        chk("imem_addr", 64'(bus.imem_addr), 64'(m_addr));
        chk("imem_wdata", 64'(bus.imem_wdata), 64'(m_wdata));
      end
      chk("cpu_rst", 64'(cpu_rst), 64'(m_mode < 2));
      chk("cpu_en", 64'(cpu_en), 64'(m_mode == 2 || m_step));
      chk("word_cnt", 64'(word_cnt), 64'(m_cnt));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    end
  end

  // Write log for literal checks
  int          wr_n = 0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0] wr_data[$];
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_n++;
      if (wr_addr.size() < 64) begin
        wr_addr.push_back(bus.imem_addr);
        wr_data.push_back(bus.imem_wdata);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic req(input bit l, input bit h, input bit r, input bit s);
    load_req = l; halt_req = h; run_req = r; step_req = s;
    @(negedge clk);
    load_req = 0; halt_req = 0; run_req = 0; step_req = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    int k = 0;
    bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
    while (bus.ld_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) chk("send_word_timeout", 64'(k), 64'(0));
    @(negedge clk);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  logic [31:0] img [3] = '{32'h0000_0093, 32'h0010_0113, 32'h0020_81B3};
  int n_en;
  int base;

  initial begin
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    rst = 1'b0;
    tick(3);
    chk("reset_state", 64'(state_o), 64'(0));
    chk("reset_cpu_rst", 64'(cpu_rst), 64'(1));
    rst = 1'b1;
    tick(2);

    // Three-word image load
    wr_addr.delete(); wr_data.delete(); base = wr_n;
    req(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send_word(img[i], i == 2);
    chk("load3_state", 64'(state_o), 64'(0));
    tick();
    chk("load3_writes", 64'(wr_n - base), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr.size()) begin
        chk("load3_addr", 64'(wr_addr[i]), 64'(i));
        chk("load3_data", 64'(wr_data[i]), 64'(img[i]));
      end
    end
    chk("load3_cnt", 64'(word_cnt), 64'(3));

    // Run, halt, two single steps
    req(0, 0, 1, 0);
    chk("run_en", 64'(cpu_en), 64'(1));
    chk("run_rst", 64'(cpu_rst), 64'(0));
    req(0, 1, 0, 0);
    n_en = 0;
    for (int c = 0; c < 12; c++) begin
      if (cpu_en) n_en++;
      step_req = (c == 2 || c == 7);
      @(negedge clk);
    end
    step_req = 0;
    chk("step_pulses", 64'(n_en), 64'(2));

    // Simultaneous requests
    req(0, 0, 1, 0);
    req(0, 1, 1, 0);
    chk("halt_over_run", 64'(state_o), 64'(3));
    req(0, 0, 1, 0);
    req(1, 1, 0, 0);
    chk("load_over_halt", 64'(state_o), 64'(1));
    chk("load_over_halt_rst", 64'(cpu_rst), 64'(1));
    send_word(32'hDEAD_BEEF, 1);
    tick();

    // ld_valid held while running and halted
    base = wr_n;
    req(0, 0, 1, 0);
    bus.ld_valid = 1'b1; bus.ld_data = 32'h1234_5678;
    tick(4);
    req(0, 1, 0, 0);
    tick(4);
    chk("valid_in_run_ready", 64'(bus.ld_ready), 64'(0));
    bus.ld_valid = 1'b0;
    tick();
    chk("valid_in_run_writes", 64'(wr_n - base), 64'(0));

    // Overflow: 4097 words without ld_last
    base = wr_n;
    req(1, 0, 0, 0);
    for (int i = 0; i < DP; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 32'(i); bus.ld_last = 1'b0;
      @(negedge clk);
    end
    bus.ld_data = 32'hFFFF_FFFF;
    chk("ovf_word4097_ready", 64'(bus.ld_ready), 64'(0));
    tick();
    bus.ld_valid = 1'b0;
    tick();
    chk("ovf_writes", 64'(wr_n - base), 64'(DP));
    chk("ovf_flag", 64'(ovf_err), 64'(1));
    chk("ovf_cnt", 64'(word_cnt), 64'(DP));
    chk("ovf_state", 64'(state_o), 64'(0));

    // Reset after the fifth word of a load
    base = wr_n;
    req(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + 32'(i), 0);
    rst = 1'b0;
    tick();
    chk("midrst_we", 64'(bus.imem_we), 64'(0));
    chk("midrst_cnt", 64'(word_cnt), 64'(0));
    chk("midrst_state", 64'(state_o), 64'(0));
    rst = 1'b1;
    tick(3);
    chk("midrst_writes", 64'(wr_n - base), 64'(5));

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      load_req     = ($urandom_range(0, 99) < 3);
      halt_req     = ($urandom_range(0, 99) < 6);
      run_req      = ($urandom_range(0, 99) < 8);
      step_req     = ($urandom_range(0, 99) < 12);
      bus.ld_valid = ($urandom_range(0, 1) == 1);
      bus.ld_data  = $urandom;
      bus.ld_last  = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    load_req = 0; halt_req = 0; run_req = 0; step_req = 0;
    bus.ld_valid = 1'b0; rst = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_boot_ctrl.md
CPU_BOOT_CTRL -- requirements
Module: cpu_boot_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12: instruction-memory word-address width.
REQ-002 Parameter DEPTH, default 4096: instruction-memory depth in words; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low (0 = reset).
REQ-005 ld_valid  input  1  load word offered.
REQ-006 ld_data  input  32  instruction word to load.
REQ-007 ld_last  input  1  marks the final word of an image; qualified by ld_valid.
REQ-008 ld_ready  output  1  controller accepts the offered load word.
REQ-009 load_req  input  1  one-cycle request to start a new image load.
REQ-010 run_req  input  1  one-cycle request to run the core.
REQ-011 halt_req  input  1  one-cycle request to pause the core.
REQ-012 step_req  input  1  one-cycle request to advance a halted core by one clock.
REQ-013 imem_we  output  1  instruction-memory write strobe.
REQ-014 imem_addr  output  ADDR_W  instruction-memory write address.
REQ-015 imem_wdata  output  32  instruction-memory write data.
REQ-016 cpu_rst  output  1  active-high reset to the core.
REQ-017 cpu_en  output  1  core clock enable; the core SHALL advance only when 1.
REQ-018 state_o  output  2  current state encoding.
REQ-019 word_cnt  output  ADDR_W+1  number of words written by the last or current load.
REQ-020 ovf_err  output  1  sticky overflow flag.

Function
REQ-021 The FSM SHALL have states IDLE=0, LOAD=1, RUN=2, HALT=3, presented on state_o.
REQ-022 IDLE: load_req -> LOAD, which clears word_cnt and ovf_err; otherwise run_req -> RUN.
REQ-023 LOAD: ld_ready=1; a handshake occurs on ld_valid&&ld_ready.
REQ-024 Each handshake SHALL assert imem_we for exactly one cycle, on the cycle after the handshake, with imem_addr=word_cnt[ADDR_W-1:0] (pre-increment value) and imem_wdata=ld_data.
REQ-025 Each handshake SHALL increment word_cnt by 1.
REQ-026 A handshake with ld_last=1 SHALL return the FSM to IDLE on the next cycle.
REQ-027 A handshake at address DEPTH-1 with ld_last=0 SHALL still write, SHALL set ovf_err, and SHALL return the FSM to IDLE; word_cnt SHALL read DEPTH.
REQ-028 RUN: cpu_rst=0 and cpu_en=1; halt_req -> HALT; load_req -> LOAD.
REQ-029 HALT: cpu_rst=0 and cpu_en=0, except cpu_en=1 for exactly the one cycle following a step_req; run_req -> RUN; load_req -> LOAD.
REQ-030 In IDLE and LOAD, cpu_rst=1 and cpu_en=0.
REQ-031 Outside LOAD, ld_ready=0 and imem_we=0, except for the trailing write owed to the final LOAD handshake.
REQ-032 Request priority when several requests are high in one cycle: load_req > halt_req > run_req > step_req.
REQ-033 Requests that are invalid in the current state SHALL be ignored with no side effects.
REQ-034 The transition from IDLE to RUN SHALL drop cpu_rst on the first cycle in RUN.

Reset
REQ-035 While rst=0 at a clock edge, outputs SHALL take these values: state=IDLE, ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, cpu_en=0, word_cnt=0, ovf_err=0.
REQ-036 Reset asserted mid-load SHALL abort the load, including any pending write.
REQ-037 Reset SHALL leave instruction-memory contents untouched.

Structure
REQ-038 The state enum and the constants ADDR_W and DEPTH SHALL reside in a shared package, cpu_pkg.
REQ-039 The block SHALL be a single module containing the FSM and the write-address counter; no sub-module.
REQ-040 The core-side connection SHALL replace the core's $readmemh preload.

Verification
REQ-041 Load 3 words (0x00000093, 0x00100113, 0x002081B3; last on the third) -> three imem_we pulses at addresses 0,1,2 one cycle after each handshake; word_cnt=3; FSM reaches IDLE.
REQ-042 run_req after a load -> cpu_rst=0 and cpu_en=1 on the next cycle; halt_req, then step_req twice -> exactly two single-cycle cpu_en pulses.
REQ-043 Stream 4097 words with ld_last=0 -> 4096 writes; ovf_err=1; word_cnt=4096; FSM in IDLE; ld_ready=0 for word 4097.
REQ-044 halt_req and run_req in the same RUN cycle -> HALT; load_req with halt_req -> LOAD, with cpu_rst=1.
REQ-045 rst=0 after word 5 of a load -> next cycle all outputs at their REQ-035 values; no further imem_we.
REQ-046 ld_valid held high in RUN and HALT -> ld_ready=0 and no imem_we.
